mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'h40000000, byte address of the first internal RAM word.
REQ-002 SHALL have parameter RAM_WORDS, default 1024, internal RAM depth in 32-bit words (power of two).
REQ-003 SHALL have parameter DEV_BASE, default 32'h80000000, device region match value.
REQ-004 SHALL have parameter DEV_MASK, default 32'hF0000000, device region match mask.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum device wait in cycles (1..255).
REQ-006 SHALL have ports, clock and reset first: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports ma_addr in 32 (byte address), ma_data_in in 32 (write data, lane 0 aligned), ma_data_out out 32 (read data, lane 0 aligned), ma_rd_req in 1, ma_wr_req in 1, ma_data_mask in 4 (lane 0 aligned byte mask: 0001/0011/1111).
REQ-008 SHALL have ports ma_done out 1 and ma_timeout out 1 (one-cycle completion/error pulses).
REQ-009 SHALL have device ports dev_addr out 32, dev_wdata out 32, dev_mask out 4, dev_rd out 1, dev_wr out 1, dev_rdata in 32, dev_ack in 1.

Function
REQ-010 SHALL implement FSM states IDLE, RAM_ACC, DEV_WAIT, RELEASE.
REQ-011 IDLE: on clock edge with exactly one of ma_rd_req/ma_wr_req high, SHALL latch ma_addr, ma_data_in, ma_data_mask and decode.
REQ-012 Lane shift: offset = addr[1:0]; effective mask = mask << offset; write data = data << 8*offset; read data returned = word >> 8*offset.
REQ-013 Effective mask overflowing bit 3 (e.g. 0011 at offset 3, 1111 at offset != 0) SHALL pulse ma_timeout, no access performed.
REQ-014 Both ma_rd_req and ma_wr_req high in IDLE SHALL pulse ma_timeout, no access performed.
REQ-015 Address in [RAM_BASE, RAM_BASE+4*RAM_WORDS) SHALL go to RAM_ACC; (addr & DEV_MASK)==DEV_BASE SHALL go to DEV_WAIT; otherwise ma_timeout pulse.
REQ-016 Error pulses SHALL occur in the cycle after the latching edge, then FSM enters RELEASE.
REQ-017 RAM_ACC: synchronous RAM, word index addr[log2(RAM_WORDS)+1:2]; writes honor effective mask per byte; ma_done asserted 2 cycles after the latching edge.
REQ-018 DEV_WAIT: dev_rd or dev_wr, dev_addr (word-aligned), dev_wdata, dev_mask SHALL be held constant until dev_ack sampled high or timeout.
REQ-019 dev_ack sampled high SHALL drop strobe next cycle, capture dev_rdata (reads), and pulse ma_done that same cycle.
REQ-020 Wait counter SHALL start at 0 on DEV_WAIT entry, increment each cycle without ack; reaching TIMEOUT_CYCLES SHALL drop strobe and pulse ma_timeout; ack on the same edge as the limit wins (done).
REQ-021 ma_done and ma_timeout SHALL be registered, never simultaneously high, each exactly one cycle.
REQ-022 ma_data_out SHALL be valid in the ma_done cycle of a read and hold until the next read completes; writes SHALL not change it.
REQ-023 RELEASE: SHALL return to IDLE on the first edge with both requests low; requests still high SHALL NOT start a new access.
REQ-024 Back-to-back: a request sampled in IDLE immediately after RELEASE SHALL be accepted with no extra bubble.

Reset
REQ-025 rst SHALL force IDLE, counter 0, ma_done=0, ma_timeout=0, dev_rd=0, dev_wr=0, ma_data_out=0, dev_addr/dev_wdata/dev_mask=0, asynchronously, including mid-access; RAM contents undefined unless written.
REQ-026 After rst release, first request SHALL be accepted on the first clock edge it is sampled high.

Verification
REQ-027 Write 32'hDEADBEEF mask 1111 to 0x40000010, then read -> ma_done 2 cycles after each latch, ma_data_out=32'hDEADBEEF.
REQ-028 Byte write 8'h5A to 0x40000013, word read 0x40000010 -> 32'h5AADBEEF; byte read 0x40000013 -> ma_data_out[7:0]=8'h5A.
REQ-029 Read 0x80000004, dev_ack after 3 cycles with dev_rdata=32'h12345678 -> dev_rd held 3 cycles, ma_done next cycle, data 32'h12345678.
REQ-030 Write 0x80000000, dev_ack never -> ma_timeout after 16 wait cycles, dev_wr drops, no ma_done.
REQ-031 Read 0x00000000 (unmapped), half read at 0x40000003, rd+wr together -> each ma_timeout one cycle after latch, no RAM/device strobe.
REQ-032 rst asserted during DEV_WAIT -> dev_rd/ma_done/ma_timeout low immediately; next request after release serviced normally.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port memory responder: decodes master requests into an internal byte-lane
// RAM or an external handshake device, reporting completion or error as one-cycle pulses.
module mem_responder #(
  parameter logic [31:0] RAM_BASE       = 32'h4000_0000,
  parameter int          RAM_WORDS      = 1024,
  parameter logic [31:0] DEV_BASE       = 32'h8000_0000,
  parameter logic [31:0] DEV_MASK       = 32'hF000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_data_in,
  output logic [31:0] ma_data_out,
  input  logic        ma_rd_req,
  input  logic        ma_wr_req,
  input  logic [3:0]  ma_data_mask,
  output logic        ma_done,
  output logic        ma_timeout,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_mask,
  output logic        dev_rd,
  output logic        dev_wr,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack
);

  localparam int          AW     = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [32:0] RAM_HI = RAM_LO + 33'(RAM_WORDS) * 33'd4;
  localparam logic [7:0]  TO_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RAM_ACC, DEV_WAIT, RELEASE} state_t;

  state_t      state_reg, state_next;
  logic        phase_reg, phase_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] lat_addr_reg, lat_addr_next;
  logic [31:0] lat_wdata_reg, lat_wdata_next;
  logic [3:0]  lat_mask_reg, lat_mask_next;
  logic        lat_wr_reg, lat_wr_next;
  logic        dev_rd_reg, dev_rd_next;
  logic        dev_wr_reg, dev_wr_next;
  logic [31:0] dout_reg, dout_next;
  logic        done_reg, done_next;
  logic        timeout_reg, timeout_next;

  logic [7:0]  emask_in;
  logic        in_ram, in_dev;
  logic [4:0]  lat_shift;

  assign emask_in  = {4'b0000, ma_data_mask} << ma_addr[1:0];
  assign in_ram    = ({1'b0, ma_addr} >= RAM_LO) && ({1'b0, ma_addr} < RAM_HI);
  assign in_dev    = (ma_addr & DEV_MASK) == DEV_BASE;
  assign lat_shift = {lat_addr_reg[1:0], 3'b000};

  // Byte-lane RAM: one array per lane so each lane's write enable stays independent.
  logic [AW-1:0] ram_idx;
  logic          ram_en;
  logic [31:0]   ram_word;

  assign ram_idx = lat_addr_reg[AW+1:2];
  assign ram_en  = (state_reg == RAM_ACC) && !phase_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_WORDS];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (ram_en) begin
          if (lat_wr_reg && lat_mask_reg[gi]) mem[ram_idx] <= lat_wdata_reg[8*gi +: 8];
          q_reg <= mem[ram_idx];
        end
      end
      assign ram_word[8*gi +: 8] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= 1'b0;
      cnt_reg       <= '0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      lat_mask_reg  <= '0;
      lat_wr_reg    <= 1'b0;
      dev_rd_reg    <= 1'b0;
      dev_wr_reg    <= 1'b0;
      dout_reg      <= '0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      cnt_reg       <= cnt_next;
      lat_addr_reg  <= lat_addr_next;
      lat_wdata_reg <= lat_wdata_next;
      lat_mask_reg  <= lat_mask_next;
      lat_wr_reg    <= lat_wr_next;
      dev_rd_reg    <= dev_rd_next;
      dev_wr_reg    <= dev_wr_next;
      dout_reg      <= dout_next;
      done_reg      <= done_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    cnt_next       = cnt_reg;
    lat_addr_next  = lat_addr_reg;
    lat_wdata_next = lat_wdata_reg;
    lat_mask_next  = lat_mask_reg;
    lat_wr_next    = lat_wr_reg;
    dev_rd_next    = dev_rd_reg;
    dev_wr_next    = dev_wr_reg;
    dout_next      = dout_reg;
    done_next      = 1'b0;
    timeout_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ma_rd_req || ma_wr_req) begin
          lat_addr_next  = ma_addr;
          lat_wdata_next = ma_data_in << {ma_addr[1:0], 3'b000};
          lat_mask_next  = emask_in[3:0];
          lat_wr_next    = ma_wr_req;
          cnt_next       = '0;
          phase_next     = 1'b0;
          if ((ma_rd_req && ma_wr_req) || (emask_in[7:4] != 4'b0000)) begin
            timeout_next = 1'b1;
            state_next   = RELEASE;
          end else if (in_ram) begin
            state_next = RAM_ACC;
          end else if (in_dev) begin
            state_next  = DEV_WAIT;
            dev_rd_next = ma_rd_req;
            dev_wr_next = ma_wr_req;
          end else begin
            timeout_next = 1'b1;
            state_next   = RELEASE;
          end
        end
      end
      RAM_ACC: begin
        // Phase 0 performs the array access; phase 1 presents the registered word.
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          done_next  = 1'b1;
          if (!lat_wr_reg) dout_next = ram_word >> lat_shift;
          state_next = RELEASE;
        end
      end
      DEV_WAIT: begin
        if (dev_ack) begin
          dev_rd_next = 1'b0;
          dev_wr_next = 1'b0;
          done_next   = 1'b1;
          if (!lat_wr_reg) dout_next = dev_rdata >> lat_shift;
          state_next  = RELEASE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next == TO_LIM) begin
            dev_rd_next  = 1'b0;
            dev_wr_next  = 1'b0;
            timeout_next = 1'b1;
            state_next   = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (!ma_rd_req && !ma_wr_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ma_data_out = dout_reg;
  assign ma_done     = done_reg;
  assign ma_timeout  = timeout_reg;
  assign dev_addr    = {lat_addr_reg[31:2], 2'b00};
  assign dev_wdata   = lat_wdata_reg;
  assign dev_mask    = lat_mask_reg;
  assign dev_rd      = dev_rd_reg;
  assign dev_wr      = dev_wr_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level reference model
// (byte-addressed RAM image, address map, device latency rules).
`timescale 1ns/1ps
module tb_mem_responder;

  localparam logic [31:0] RAM_BASE = 32'h4000_0000;
  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] DEV_BASE = 32'h8000_0000;
  localparam logic [31:0] DEV_MASK = 32'hF000_0000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ma_addr, ma_data_in, ma_data_out;
  logic        ma_rd_req, ma_wr_req;
  logic [3:0]  ma_data_mask;
  logic        ma_done, ma_timeout;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [3:0]  dev_mask;
  logic        dev_rd, dev_wr, dev_ack;

  int n_chk  = 0;
  int n_pass = 0;
  int n_txn  = 0;
  logic [31:0] exp_dout;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  mem_responder #(
    .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .DEV_BASE(DEV_BASE),
    .DEV_MASK(DEV_MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ma_addr(ma_addr), .ma_data_in(ma_data_in), .ma_data_out(ma_data_out),
    .ma_rd_req(ma_rd_req), .ma_wr_req(ma_wr_req), .ma_data_mask(ma_data_mask),
    .ma_done(ma_done), .ma_timeout(ma_timeout),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_mask(dev_mask),
    .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One master transaction. ack_after: edge index (after the latch edge) on which the
  // device acknowledges; 0 means the device never answers. hold: extra cycles the
  // master keeps its request asserted after the completion pulse.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] mask,
                     input int ack_after, input logic [31:0] rdata, input int hold);
    int          off, kind, exp_k, exp_strb, k, got_k, strb, hold_err;
    logic [7:0]  em;
    logic [31:0] sh, word, f_addr, f_wdata;
    logic [3:0]  f_mask;
    logic [1:0]  f_rw, exp_pulse, got_pulse;
    longint      a;
    int          idx;

    // Reference model: decide the outcome from the address map and lane rules.
    off = int'(addr[1:0]);
    em  = {4'b0000, mask} << off;
    sh  = data << (8 * off);
    a   = longint'(addr);
    if (rd && wr)                 kind = 0;
    else if (em[7:4] != 4'b0000)  kind = 0;
    else if (a >= longint'(RAM_BASE) && a < longint'(RAM_BASE) + 4 * RAM_WORDS) kind = 1;
    else if ((addr & DEV_MASK) == DEV_BASE) kind = 2;
    else                          kind = 0;

    exp_strb = 0;
    case (kind)
      0: begin exp_k = 0; exp_pulse = 2'b01; end
      1: begin
        exp_k = 2; exp_pulse = 2'b10;
        idx = int'((addr - RAM_BASE) >> 2);
        if (!ref_mem.exists(idx)) ref_mem[idx] = 32'h0;
        if (wr) begin
          word = ref_mem[idx];
          for (int i = 0; i < 4; i++) if (em[i]) word[8*i +: 8] = sh[8*i +: 8];
          ref_mem[idx] = word;
        end else begin
          exp_dout = ref_mem[idx] >> (8 * off);
        end
      end
      default: begin
        if (ack_after >= 1 && ack_after <= TO) begin
          exp_k = ack_after; exp_pulse = 2'b10;
          if (rd) exp_dout = rdata >> (8 * off);
        end else begin
          exp_k = TO; exp_pulse = 2'b01;
        end
        exp_strb = exp_k;
      end
    endcase

    @(negedge clk);
    ma_addr = addr; ma_data_in = data; ma_data_mask = mask;
    ma_rd_req = rd; ma_wr_req = wr; dev_ack = 1'b0; dev_rdata = rdata;
    @(posedge clk); #1;

    k = 0; got_k = -1; strb = 0; hold_err = 0; got_pulse = 2'b00;
    f_addr = '0; f_wdata = '0; f_mask = '0; f_rw = 2'b00;
    while (k <= 40) begin
      if (dev_rd || dev_wr) begin
        if (strb == 0) begin
          f_addr = dev_addr; f_wdata = dev_wdata; f_mask = dev_mask; f_rw = {dev_rd, dev_wr};
        end else if (dev_addr !== f_addr || dev_wdata !== f_wdata || dev_mask !== f_mask ||
                     {dev_rd, dev_wr} !== f_rw) begin
          hold_err++;
        end
        strb++;
      end
      if (ma_done || ma_timeout) begin
        got_k = k; got_pulse = {ma_done, ma_timeout};
        break;
      end
      @(negedge clk);
      dev_ack = (ack_after != 0) && (k + 1 == ack_after);
      @(posedge clk); #1;
      k++;
    end

    check("pulse_kind", 32'(got_pulse), 32'(exp_pulse));
    check("latency", 32'(got_k), 32'(exp_k));
    check("strobe_cycles", 32'(strb), 32'(exp_strb));
    check("data_out", ma_data_out, exp_dout);
    if (kind == 2) begin
      check("dev_addr", f_addr, {addr[31:2], 2'b00});
      check("dev_mask", 32'(f_mask), 32'(em[3:0]));
      check("dev_rw", 32'(f_rw), {30'd0, rd, wr});
      if (wr) check("dev_wdata", f_wdata, sh);
      check("dev_hold", 32'(hold_err), 32'd0);
    end

    @(negedge clk);
    dev_ack = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("held_quiet", {28'd0, ma_done, ma_timeout, dev_rd, dev_wr}, 32'd0);
      @(negedge clk);
    end
    ma_rd_req = 1'b0; ma_wr_req = 1'b0;
    @(posedge clk); #1;
    check("pulse_len", {30'd0, ma_done, ma_timeout}, 32'd0);

    $display("txn %0d rd=%0b wr=%0b addr=%h data=%h mask=%h ack=%0d -> k=%0d pulse=%b dout=%h",
             n_txn, rd, wr, addr, data, mask, ack_after, got_k, got_pulse, ma_data_out);
    n_txn++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  masks [3];
    logic [31:0] unmapped [5];
    int sel, r;
    logic [31:0] addr;

    masks[0] = 4'h1; masks[1] = 4'h3; masks[2] = 4'hF;
    unmapped[0] = 32'h0000_0000; unmapped[1] = 32'h4000_1000; unmapped[2] = 32'h3FFF_FFFC;
    unmapped[3] = 32'h7FFF_FFFF; unmapped[4] = 32'h9000_0000;

    rst = 1'b1; ma_addr = '0; ma_data_in = '0; ma_data_mask = '0;
    ma_rd_req = 1'b0; ma_wr_req = 1'b0; dev_ack = 1'b0; dev_rdata = '0;
    exp_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {28'd0, ma_done, ma_timeout, dev_rd, dev_wr}, 32'd0);
    check("rst_dout", ma_data_out, 32'd0);
    check("rst_dev_addr", dev_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    txn(0, 1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0);
    txn(1, 0, 32'h4000_0010, 32'h0, 4'hF, 0, 32'h0, 0);
    txn(0, 1, 32'h4000_0013, 32'h0000_005A, 4'h1, 0, 32'h0, 0);
    txn(1, 0, 32'h4000_0010, 32'h0, 4'hF, 0, 32'h0, 0);
    txn(1, 0, 32'h4000_0013, 32'h0, 4'h1, 0, 32'h0, 0);
    txn(1, 0, 32'h8000_0004, 32'h0, 4'hF, 3, 32'h1234_5678, 0);
    txn(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 0);
    txn(1, 0, 32'h0000_0000, 32'h0, 4'hF, 0, 32'h0, 0);
    txn(1, 0, 32'h4000_0003, 32'h0, 4'h3, 0, 32'h0, 0);
    txn(1, 1, 32'h4000_0010, 32'h0, 4'hF, 0, 32'h0, 0);
    txn(1, 0, 32'h8000_0102, 32'h0, 4'h3, TO, 32'hA1B2_C3D4, 3);
    txn(0, 1, 32'h4000_0FFC, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 0);
    txn(1, 0, 32'h4000_0FFE, 32'h0, 4'h3, 0, 32'h0, 2);
    txn(1, 0, 32'h4000_1000, 32'h0, 4'hF, 0, 32'h0, 0);

    // Asynchronous reset in the middle of a device wait
    @(negedge clk);
    ma_addr = 32'h8000_0008; ma_rd_req = 1'b1; dev_ack = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_strobe", {30'd0, dev_rd, dev_wr}, 32'd0);
    check("mid_rst_pulse", {30'd0, ma_done, ma_timeout}, 32'd0);
    check("mid_rst_dout", ma_data_out, 32'd0);
    @(negedge clk);
    ma_rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_dout = '0;
    txn(1, 0, 32'h8000_000C, 32'h0, 4'hF, 2, 32'h5566_7788, 0);

    // Fill a RAM window so random reads have defined contents
    for (int i = 0; i < 16; i++) txn(0, 1, RAM_BASE + 32'(4 * i), $urandom, 4'hF, 0, 32'h0, 0);

    for (int t = 0; t < 120; t++) begin
      sel = $urandom_range(0, 9);
      r   = $urandom_range(0, 1);
      if (sel <= 4)      addr = RAM_BASE + 32'($urandom_range(0, 63));
      else if (sel <= 7) addr = DEV_BASE | 32'($urandom_range(0, 255));
      else               addr = unmapped[$urandom_range(0, 4)];
      txn((sel == 9) ? 1'b1 : r[0], (sel == 9) ? 1'b1 : !r[0], addr, $urandom,
          masks[$urandom_range(0, 2)], $urandom_range(1, 20), $urandom, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
